// File: rtl/mul_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_unit_pkg
// Description : Shared ALU op codes, multiplier FSM states and sizing constants
// Revision    : 1.0 - initial release
// ============================================================================
package mul_unit_pkg;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_ORR   = 3'b011,
        ALU_EOR   = 3'b100,
        ALU_MUL   = 3'b101,
        ALU_UMULL = 3'b110,
        ALU_SMULL = 3'b111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int c_width = 32;
    localparam int c_iters = c_width;
    localparam int c_cnt_w = $clog2(c_iters);

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == ALU_MUL) || (op == ALU_UMULL) || (op == ALU_SMULL);
    endfunction

endpackage : mul_unit_pkg
`default_nettype wire

// File: rtl/mul_sign_fix.sv
`default_nettype none
// ============================================================================
// Module      : mul_sign_fix
// Description : Operand magnitudes/sign for SMULL at latch time, and the final
//               conditional negation, word split and {N,Z} flag generation.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_sign_fix
    import mul_unit_pkg::*;
#(
    parameter int WIDTH = c_width
) (
    input  logic [2:0]         i_op,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [WIDTH-1:0]   o_mag_a,
    output logic [WIDTH-1:0]   o_mag_b,
    output logic               o_sign,
    input  logic [2:0]         i_op_lat,
    input  logic               i_sign_lat,
    input  logic [2*WIDTH-1:0] i_prod,
    output logic [WIDTH-1:0]   o_res_lo,
    output logic [WIDTH-1:0]   o_res_hi,
    output logic [1:0]         o_flags
);

    logic                 w_is_signed;
    logic [2*WIDTH-1:0]   w_prod_fix;

    // Magnitude of the most negative value wraps to itself, read as unsigned.
    assign w_is_signed = (i_op == ALU_SMULL);
    assign o_mag_a     = (w_is_signed && i_a[WIDTH-1]) ? -i_a : i_a;
    assign o_mag_b     = (w_is_signed && i_b[WIDTH-1]) ? -i_b : i_b;
    assign o_sign      = w_is_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);

    assign w_prod_fix  = i_sign_lat ? -i_prod : i_prod;

    always_comb begin
        o_res_lo = w_prod_fix[WIDTH-1:0];
        o_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        o_flags  = {w_prod_fix[2*WIDTH-1], (w_prod_fix == '0)};
        if (i_op_lat == ALU_MUL) begin
            o_res_hi = '0;
            o_flags  = {w_prod_fix[WIDTH-1], (w_prod_fix[WIDTH-1:0] == '0)};
        end
    end

endmodule : mul_sign_fix
`default_nettype wire

// File: rtl/mul_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_unit
// Description : Iterative radix-2 shift-add multiplier for MUL/UMULL/SMULL.
//               Define MUL_EARLY_EXIT_EN to stop once the multiplier is spent.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int WIDTH = c_width,
    parameter int ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [1:0]       mul_flags
);

    localparam int                 c_cnt_w    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(ITERS - 1);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH:0]     r_acc;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2:0]           r_op;
    logic                 r_sign;

    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH:0]     w_step;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 w_sign;
    logic [WIDTH-1:0]     w_res_lo;
    logic [WIDTH-1:0]     w_res_hi;
    logic [1:0]           w_flags;

    assign w_accept = start && is_mul_op(ALUControl);
    assign busy     = (r_state != IDLE);

    // Add into the upper half (carry lands in the extra top bit), then shift.
    assign w_sum  = r_acc[2*WIDTH:WIDTH] + {1'b0, (r_mplier[0] ? r_mcand : '0)};
    assign w_step = {w_sum, r_acc[WIDTH-1:0]} >> 1;

`ifdef MUL_EARLY_EXIT_EN
    logic                 r_align;
    logic [c_cnt_w-1:0]   w_resid;

    // After k iterations the partial product sits (ITERS-k) bits too high.
    assign w_last  = (r_cnt == c_last_cnt) || (r_mplier[WIDTH-1:1] == '0);
    assign w_resid = c_last_cnt - r_cnt;
`else
    assign w_last  = (r_cnt == c_last_cnt);
`endif

    mul_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .i_op       (ALUControl),
        .i_a        (a),
        .i_b        (b),
        .o_mag_a    (w_mag_a),
        .o_mag_b    (w_mag_b),
        .o_sign     (w_sign),
        .i_op_lat   (r_op),
        .i_sign_lat (r_sign),
        .i_prod     (r_acc[2*WIDTH-1:0]),
        .o_res_lo   (w_res_lo),
        .o_res_hi   (w_res_hi),
        .o_flags    (w_flags)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = RUN;
`ifdef MUL_EARLY_EXIT_EN
            RUN:  if (r_align) w_state_nxt = DONE;
`else
            RUN:  if (w_last) w_state_nxt = DONE;
`endif
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_op      <= '0;
            r_sign    <= 1'b0;
            done      <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            mul_flags <= '0;
`ifdef MUL_EARLY_EXIT_EN
            r_align   <= 1'b0;
`endif
        end else begin
            done <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= w_mag_a;
                        r_mplier <= w_mag_b;
                        r_sign   <= w_sign;
                        r_op     <= ALUControl;
                        r_acc    <= '0;
                        r_cnt    <= '0;
`ifdef MUL_EARLY_EXIT_EN
                        r_align  <= 1'b0;
`endif
                    end
                end
                RUN: begin
`ifdef MUL_EARLY_EXIT_EN
                    if (r_align) begin
                        r_acc <= r_acc >> w_resid;
                    end else begin
                        r_acc    <= w_step;
                        r_mplier <= r_mplier >> 1;
                        if (w_last) r_align <= 1'b1;
                        else        r_cnt   <= r_cnt + 1'b1;
                    end
`else
                    r_acc    <= w_step;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
`endif
                end
                DONE: begin
                    result_lo <= w_res_lo;
                    result_hi <= w_res_hi;
                    mul_flags <= w_flags;
                end
                default: ;
            endcase
        end
    end

endmodule : mul_unit
`default_nettype wire

// File: tb/tb_mul_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_unit
// Description : Directed vector table plus hand-written busy/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  ALUControl;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic [1:0]  mul_flags;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] c_op_mul   = 3'b101;
    localparam logic [2:0] c_op_umull = 3'b110;
    localparam logic [2:0] c_op_smull = 3'b111;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [1:0]  fl;
    } vec_t;

    vec_t vecs [13];

    mul_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ALUControl (ALUControl),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result_lo  (result_lo),
        .result_hi  (result_hi),
        .mul_flags  (mul_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected edge index of the done pulse, counted from the start edge E0.
    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] bv);
`ifdef MUL_EARLY_EXIT_EN
        logic [31:0] m;
        int          n;
        m = (op == c_op_smull && bv[31]) ? (32'd0 - bv) : bv;
        n = 1;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        return n + 2;
`else
        return (op == c_op_smull && bv == 32'd0) ? 33 : 33;
`endif
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] ta, input logic [31:0] tbv,
                         input int poke_k, output int lat, output logic busy_bad);
        @(negedge clk);
        ALUControl = op; a = ta; b = tbv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; ALUControl = 3'b000; a = $urandom; b = $urandom;
        lat = -1;
        busy_bad = !busy;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == poke_k) begin
                start = 1'b1; ALUControl = c_op_mul; a = 32'd5; b = 32'd5;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = k;
                if (busy) busy_bad = 1'b1;
                break;
            end
            if (!busy) busy_bad = 1'b1;
        end
    endtask

    task automatic quiet_window(input string nm, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (busy || done) seen = 1'b1;
        end
        chk(nm, {63'd0, seen}, 64'd0);
    endtask

    initial begin
        int   lat;
        logic bb;

        vecs[0]  = '{c_op_umull, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 2'b10};
        vecs[1]  = '{c_op_smull, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFF, 2'b10};
        vecs[2]  = '{c_op_smull, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 2'b00};
        vecs[3]  = '{c_op_mul,   32'h00010000, 32'h00010000, 32'h00000000, 32'h00000000, 2'b01};
        vecs[4]  = '{c_op_umull, 32'd7,        32'd3,        32'd21,       32'h00000000, 2'b00};
        vecs[5]  = '{c_op_umull, 32'd7,        32'd0,        32'd0,        32'h00000000, 2'b01};
        vecs[6]  = '{c_op_mul,   32'h12345678, 32'h00000010, 32'h23456780, 32'h00000000, 2'b00};
        vecs[7]  = '{c_op_mul,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 2'b00};
        vecs[8]  = '{c_op_smull, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 32'hFFFFFFFF, 2'b10};
        vecs[9]  = '{c_op_smull, 32'hFFFFFFF9, 32'hFFFFFFFA, 32'h0000002A, 32'h00000000, 2'b00};
        vecs[10] = '{c_op_umull, 32'h80000000, 32'h00000002, 32'h00000000, 32'h00000001, 2'b00};
        vecs[11] = '{c_op_mul,   32'h00008000, 32'h00010000, 32'h80000000, 32'h00000000, 2'b10};
        vecs[12] = '{c_op_smull, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 2'b01};

        reset = 1'b1; start = 1'b0; ALUControl = 3'b000; a = '0; b = '0;
        @(posedge clk); #1;
        chk("rst_busy",  {63'd0, busy}, 64'd0);
        chk("rst_done",  {63'd0, done}, 64'd0);
        chk("rst_lo",    {32'd0, result_lo}, 64'd0);
        chk("rst_hi",    {32'd0, result_hi}, 64'd0);
        chk("rst_flags", {62'd0, mul_flags}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].op, vecs[i].va, vecs[i].vb, 0, lat, bb);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].op, vecs[i].vb)));
            chk($sformatf("v%0d_lo", i), {32'd0, result_lo}, {32'd0, vecs[i].lo});
            chk($sformatf("v%0d_hi", i), {32'd0, result_hi}, {32'd0, vecs[i].hi});
            chk($sformatf("v%0d_flags", i), {62'd0, mul_flags}, {62'd0, vecs[i].fl});
            chk($sformatf("v%0d_busy", i), {63'd0, bb}, 64'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
        end

        // Non-multiply op code must not start the unit.
        @(negedge clk);
        start = 1'b1; ALUControl = 3'b000; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        quiet_window("badop_ignored", 40);
        chk("badop_lo_hold", {32'd0, result_lo}, 64'd0);
        chk("badop_flags_hold", {62'd0, mul_flags}, 64'd1);

        // Second start at E5 while busy is dropped, not queued.
        issue(c_op_umull, 32'h00001000, 32'h80000001, 5, lat, bb);
        chk("busy_start_latency", 64'(lat), 64'(exp_lat(c_op_umull, 32'h80000001)));
        chk("busy_start_lo", {32'd0, result_lo}, 64'h00001000);
        chk("busy_start_hi", {32'd0, result_hi}, 64'h00000800);
        chk("busy_start_flags", {62'd0, mul_flags}, 64'd0);
        quiet_window("busy_start_no_queue", 40);

        // Asynchronous reset at E10 aborts the operation.
        @(negedge clk);
        start = 1'b1; ALUControl = c_op_umull; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy",  {63'd0, busy}, 64'd0);
        chk("midrst_done",  {63'd0, done}, 64'd0);
        chk("midrst_lo",    {32'd0, result_lo}, 64'd0);
        chk("midrst_hi",    {32'd0, result_hi}, 64'd0);
        chk("midrst_flags", {62'd0, mul_flags}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        quiet_window("midrst_no_done", 40);

        issue(c_op_smull, 32'hFFFFFFFD, 32'h00000005, 0, lat, bb);
        chk("post_rst_latency", 64'(lat), 64'(exp_lat(c_op_smull, 32'h00000005)));
        chk("post_rst_lo", {32'd0, result_lo}, 64'hFFFFFFF1);
        chk("post_rst_hi", {32'd0, result_hi}, 64'hFFFFFFFF);
        chk("post_rst_flags", {62'd0, mul_flags}, 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mul_unit
`default_nettype wire

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Iterative radix-2 shift-add multiplier next to the ALU in the execute stage.
- Executes the three multiply encodings of the ALU control field: 101 MUL, 110 UMULL, 111 SMULL.
- Returns a 64-bit product as a low and a high word, plus N/Z flags, to the write-back/flag logic.
- The controller stalls the pipeline while busy=1.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH.
- ITERS, WIDTH, number of shift-add iterations on the full-latency path.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- ALUControl  input  3  operation code; only 101, 110 and 111 are accepted.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- result_lo  output  WIDTH  low product word (the Result word for MUL).
- result_hi  output  WIDTH  high product word (the second result word for UMULL/SMULL).
- mul_flags  output  2  {N,Z}; the consumer leaves C and V unchanged.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; busy=0, done=0, result_lo=0, result_hi=0, mul_flags=0; all internal registers cleared. Reset mid-operation aborts the operation with no done pulse.
- States:
  - IDLE: on start=1 with ALUControl in {101,110,111}, latch operands and the op code, then go to RUN. start with any other code is ignored; stay in IDLE.
  - RUN: each cycle, if multiplier LSB=1 add the multiplicand into the upper half of the 2*WIDTH+1 accumulator, then shift the accumulator right by 1. Iteration counter runs 0..ITERS-1; go to DONE after the last iteration.
  - DONE: register results and flags, assert done for exactly this one cycle, then return to IDLE.
- Latency: start sampled at edge E0; RUN occupies E1..E32; outputs update and done rises at E33; IDLE at E34. A new start is accepted at E34.
- Signed handling (SMULL only): latch |a| and |b| and sign = a[31]^b[31]. In DONE, negate the 64-bit product (two's complement) if sign=1. |0x80000000| is treated as unsigned 0x80000000, so no overflow case exists.
- UMULL: operands unsigned, no sign fix.
- MUL: result_lo = product[31:0]; result_hi = 0 by definition.
- Flags:
  - MUL: N = result_lo[31], Z = (result_lo == 0).
  - UMULL/SMULL: N = result_hi[31], Z = ({result_hi,result_lo} == 0).
- Output hold: outputs hold their last values until the next DONE. start while busy is ignored, with no queueing. a, b and ALUControl may change freely after E0.
- Zero operand: the full iteration count still runs; result is 0 and Z=1.

Optional Feature:
- MUL_EARLY_EXIT_EN defined:
  - RUN exits once the remaining (shifted) multiplier bits are all zero after an iteration; minimum 1 iteration.
  - The accumulator receives the residual right-shift so the product alignment is identical.
  - Latency = iterations + 2 edges to done. Example: b=3 gives 2 iterations, so done rises at E4.
- MUL_EARLY_EXIT_EN undefined: fixed 32 iterations, done always at E33.
- Results are bit-identical in both builds.

Decomposition:
- Shared package:
  - ALUControl encodings ALU_ADD..ALU_SMULL (3'b000..3'b111).
  - State typedef {IDLE, RUN, DONE}.
  - WIDTH default and iteration-counter width ($clog2(ITERS)).
- One natural sub-module, mul_sign_fix (combinational):
  - Computes operand magnitudes and the sign bit at latch time.
  - Performs the conditional 64-bit negation and N/Z generation in DONE.
- The FSM, accumulator and counter stay in mul_unit.

Test Plan:
- UMULL a=0xFFFFFFFF, b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001, N=1, Z=0; done is a single pulse at E33; busy high E1..E33.
- SMULL a=0xFFFFFFFF (-1), b=0x00000002 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFFE, N=1.
- SMULL a=0x80000000, b=0x80000000 -> result_hi=0x40000000, result_lo=0x00000000, N=0, Z=0.
- MUL a=0x00010000, b=0x00010000 -> result_lo=0, result_hi=0, Z=1. start with ALUControl=000 -> busy stays 0 and no done.
- start pulsed again at E5 with new operands -> ignored; the first result is unchanged. reset asserted at E10 -> busy=0 and outputs=0 immediately, no done; the next start gives a correct result.
- MUL_EARLY_EXIT_EN build, UMULL a=7, b=3 -> result_lo=21, done at E4. With b=0, done at E3 and Z=1.
